pixel_streamer: RTL and testbench

PIXEL_STREAMER -- requirements
Module: pixel_streamer

---
 rtl/pixel_streamer.sv | 127 ++++++++++++
 tb/tb_pixel_streamer.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_streamer.sv
// Pulls BYTES_PER_PIXEL bytes from a latency-FIFO_LATENCY FIFO and presents them as one pixel.
// Define PIXEL_STREAMER_UNDERRUN_COUNT_EN to add the saturating underrun_count output.
module pixel_streamer #(
    parameter int unsigned DATA_WIDTH      = 8,
    parameter int unsigned BYTES_PER_PIXEL = 2,
    parameter int unsigned FIFO_LATENCY    = 1
) (
    input  logic                                  clockout,
    input  logic                                  reset,
    input  logic                                  enable,
    input  logic [DATA_WIDTH-1:0]                 fifo_data,
    input  logic                                  fifo_empty,
    output logic                                  fifo_read,
    output logic [DATA_WIDTH*BYTES_PER_PIXEL-1:0] pixel_data,
    output logic                                  pixel_valid,
    input  logic                                  pixel_ready,
    output logic                                  underrun
`ifdef PIXEL_STREAMER_UNDERRUN_COUNT_EN
    ,
    output logic [15:0]                           underrun_count
`endif
);

    localparam int unsigned PixW = DATA_WIDTH * BYTES_PER_PIXEL;
    localparam int unsigned IdxW = (BYTES_PER_PIXEL > 1) ? $clog2(BYTES_PER_PIXEL) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(BYTES_PER_PIXEL - 1);
    localparam logic WaitLast = 1'(FIFO_LATENCY - 1);

    typedef enum logic [1:0] {StIdle, StFetch, StWait, StPresent} state_e;

    state_e          state_q, state_d;
    logic [IdxW-1:0] byte_idx_q, byte_idx_d;
    logic            wait_cnt_q, wait_cnt_d;
    logic            stalled_q, stalled_d;
    logic [PixW-1:0] pixel_q, pixel_d;
    logic            capture;

    always_comb begin
        state_d    = state_q;
        byte_idx_d = byte_idx_q;
        wait_cnt_d = wait_cnt_q;
        stalled_d  = 1'b0;
        fifo_read  = 1'b0;
        underrun   = 1'b0;
        capture    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (enable) state_d = StFetch;
            end
            StFetch: begin
                // Only a pixel that has not started may be abandoned.
                if (!enable && byte_idx_q == '0) begin
                    state_d = StIdle;
                end else if (fifo_empty) begin
                    stalled_d = 1'b1;
                    underrun  = !stalled_q;
                end else begin
                    fifo_read  = 1'b1;
                    wait_cnt_d = 1'b0;
                    state_d    = StWait;
                end
            end
            StWait: begin
                if (wait_cnt_q == WaitLast) begin
                    capture = 1'b1;
                    if (byte_idx_q == LastIdx) begin
                        byte_idx_d = '0;
                        state_d    = StPresent;
                    end else begin
                        byte_idx_d = byte_idx_q + 1'b1;
                        state_d    = StFetch;
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            StPresent: begin
                if (pixel_ready) state_d = enable ? StFetch : StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // First popped byte lands in the least significant slot.
    always_comb begin
        pixel_d = pixel_q;
        if (capture) begin
            for (int unsigned k = 0; k < BYTES_PER_PIXEL; k++) begin
                if (byte_idx_q == IdxW'(k)) pixel_d[k*DATA_WIDTH +: DATA_WIDTH] = fifo_data;
            end
        end
    end

    always_ff @(posedge clockout or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            byte_idx_q <= '0;
            wait_cnt_q <= 1'b0;
            stalled_q  <= 1'b0;
            pixel_q    <= '0;
        end else begin
            state_q    <= state_d;
            byte_idx_q <= byte_idx_d;
            wait_cnt_q <= wait_cnt_d;
            stalled_q  <= stalled_d;
            pixel_q    <= pixel_d;
        end
    end

    assign pixel_valid = (state_q == StPresent);
    assign pixel_data  = pixel_q;

`ifdef PIXEL_STREAMER_UNDERRUN_COUNT_EN
    logic [15:0] underrun_count_q;

    always_ff @(posedge clockout or posedge reset) begin
        if (reset) begin
            underrun_count_q <= '0;
        end else if (underrun && underrun_count_q != 16'hFFFF) begin
            underrun_count_q <= underrun_count_q + 16'd1;
        end
    end

    assign underrun_count = underrun_count_q;
`endif

endmodule

// File: tb/tb_pixel_streamer.sv
// Directed bench for pixel_streamer: default instance plus a 3-byte, latency-2 instance,
// each fed by a small FIFO model; a scoreboard assembles pixels from the bytes actually popped.
module tb_pixel_streamer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    // Default instance: 2 bytes per pixel, latency 1
    logic        en_a = 1'b0, ready_a = 1'b1, force_empty_a = 1'b0;
    logic        empty_a, rd_a, valid_a, underrun_a;
    logic [7:0]  fdata_a;
    logic [15:0] pix_a;
    logic [7:0]  mem_a [0:31];
    int          wp_a = 0, rp_a = 0;

    // Second instance: 3 bytes per pixel, latency 2
    logic        en_b = 1'b0, ready_b = 1'b1;
    logic        empty_b, rd_b, valid_b, underrun_b;
    logic [7:0]  fdata_b, stage_b;
    logic [23:0] pix_b;
    logic [7:0]  mem_b [0:7];
    int          wp_b = 0, rp_b = 0;

`ifdef PIXEL_STREAMER_UNDERRUN_COUNT_EN
    logic [15:0] ucnt_a, ucnt_b;
`endif

    assign empty_a = force_empty_a || (rp_a == wp_a);
    assign empty_b = (rp_b == wp_b);

    // FIFO models drive junk whenever the data is not meant to be valid.
    always @(posedge clk) begin
        fdata_a <= rd_a ? mem_a[rp_a] : 8'hEE;
        if (rd_a) rp_a <= rp_a + 1;
        stage_b <= rd_b ? mem_b[rp_b] : 8'hEE;
        fdata_b <= stage_b;
        if (rd_b) rp_b <= rp_b + 1;
    end

    pixel_streamer dut_a (
        .clockout   (clk),
        .reset      (rst),
        .enable     (en_a),
        .fifo_data  (fdata_a),
        .fifo_empty (empty_a),
        .fifo_read  (rd_a),
        .pixel_data (pix_a),
        .pixel_valid(valid_a),
        .pixel_ready(ready_a),
        .underrun   (underrun_a)
`ifdef PIXEL_STREAMER_UNDERRUN_COUNT_EN
        ,
        .underrun_count(ucnt_a)
`endif
    );

    pixel_streamer #(
        .DATA_WIDTH     (8),
        .BYTES_PER_PIXEL(3),
        .FIFO_LATENCY   (2)
    ) dut_b (
        .clockout   (clk),
        .reset      (rst),
        .enable     (en_b),
        .fifo_data  (fdata_b),
        .fifo_empty (empty_b),
        .fifo_read  (rd_b),
        .pixel_data (pix_b),
        .pixel_valid(valid_b),
        .pixel_ready(ready_b),
        .underrun   (underrun_b)
`ifdef PIXEL_STREAMER_UNDERRUN_COUNT_EN
        ,
        .underrun_count(ucnt_b)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every accepted pixel must be the next two popped bytes, LSB first.
    initial begin : compare
        logic [7:0]  popped[$];
        logic        prev_hold;
        logic [15:0] prev_pix;
        logic [15:0] expv;
        int          gap;
        prev_hold = 1'b0;
        prev_pix  = '0;
        gap       = 100;
        forever begin
            @(negedge clk);
            if (rst) begin
                popped.delete();
                prev_hold = 1'b0;
                check("reset_quiet_a", {13'd0, rd_a, valid_a, underrun_a, pix_a}, 32'd0);
            end else begin
                gap++;
                if (rd_a) begin
                    check("read_spacing", 32'(gap >= 2), 32'd1);
                    check("read_while_empty", 32'(empty_a), 32'd0);
                    popped.push_back(mem_a[rp_a]);
                    gap = 0;
                end
                if (prev_hold) begin
                    check("held_valid", 32'(valid_a), 32'd1);
                    check("held_data", 32'(pix_a), 32'(prev_pix));
                end
                if (valid_a) begin
                    check("read_in_present", 32'(rd_a), 32'd0);
                    if (ready_a) begin
                        if (popped.size() >= 2) begin
                            expv = {popped[1], popped[0]};
                            void'(popped.pop_front());
                            void'(popped.pop_front());
                            check("sb_pixel", 32'(pix_a), 32'(expv));
                        end else begin
                            check("sb_bytes_available", 32'(popped.size()), 32'd2);
                        end
                    end
                end
                prev_hold = valid_a && !ready_a;
                prev_pix  = pix_a;
            end
        end
    end

    initial begin : stimulus
        int n;
        logic [7:0] init_a [0:11];
        init_a = '{8'h34, 8'h12, 8'h78, 8'h56, 8'h34, 8'h12,
                   8'hCD, 8'hAB, 8'h11, 8'h99, 8'h22, 8'h33};
        for (int i = 0; i < 12; i++) mem_a[i] = init_a[i];
        wp_a = 12;
        mem_b[0] = 8'hAA;
        mem_b[1] = 8'hBB;
        mem_b[2] = 8'hCC;
        wp_b = 3;

        // Reset state
        step();
        step();
        #2;
        check("rst_read", 32'(rd_a), 32'd0);
        check("rst_valid", 32'(valid_a), 32'd0);
        check("rst_pixel", 32'(pix_a), 32'd0);
        check("rst_underrun", 32'(underrun_a), 32'd0);
        check("rst_pixel_b", 32'(pix_b), 32'd0);
`ifdef PIXEL_STREAMER_UNDERRUN_COUNT_EN
        check("rst_ucnt", 32'(ucnt_a), 32'd0);
`endif

        // Basic pixel: two reads, pixel on the fifth cycle after IDLE
        rst  = 1'b0;
        en_a = 1'b1;
        n    = 0;
        for (int k = 1; k <= 5; k++) begin
            step();
            n += int'(rd_a);
            if (k == 1) check("t1_read_c1", 32'(rd_a), 32'd1);
            if (k == 4) check("t1_valid_c4", 32'(valid_a), 32'd0);
        end
        check("t1_reads", 32'(n), 32'd2);
        check("t1_valid", 32'(valid_a), 32'd1);
        check("t1_pixel", 32'(pix_a), 32'h1234);
        en_a = 1'b0;
        step();
        check("t1_valid_drop", 32'(valid_a), 32'd0);
        step();
        check("t1_idle_no_read", 32'(rd_a), 32'd0);

        // Back-pressure: ten cycles without ready
        en_a    = 1'b1;
        ready_a = 1'b0;
        for (int k = 1; k <= 5; k++) step();
        check("t2_valid", 32'(valid_a), 32'd1);
        check("t2_pixel", 32'(pix_a), 32'h5678);
        en_a = 1'b0;
        n    = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            n += int'(rd_a);
            if (!valid_a || pix_a != 16'h5678) n += 100;
        end
        check("t2_hold_ok", 32'(n), 32'd0);
        ready_a = 1'b1;
        #2;
        check("t2_still_valid", 32'(valid_a), 32'd1);
        step();
        check("t2_accepted", 32'(valid_a), 32'd0);

        // FIFO stall of four cycles between byte 0 and byte 1
        en_a = 1'b1;
        step();
        check("t3_read0", 32'(rd_a), 32'd1);
        step();
        force_empty_a = 1'b1;
`ifdef PIXEL_STREAMER_UNDERRUN_COUNT_EN
        check("t3_ucnt_before", 32'(ucnt_a), 32'd0);
`endif
        step();
        check("t3_underrun", 32'(underrun_a), 32'd1);
        check("t3_no_read", 32'(rd_a), 32'd0);
        n = 1;
        for (int k = 4; k <= 6; k++) begin
            step();
            n += int'(underrun_a) + int'(rd_a);
        end
        check("t3_one_pulse", 32'(n), 32'd1);
`ifdef PIXEL_STREAMER_UNDERRUN_COUNT_EN
        check("t3_ucnt_after", 32'(ucnt_a), 32'd1);
`endif
        step();
        force_empty_a = 1'b0;
        #2;
        check("t3_read1", 32'(rd_a), 32'd1);
        check("t3_no_new_pulse", 32'(underrun_a), 32'd0);
        step();
        step();
        check("t3_valid", 32'(valid_a), 32'd1);
        check("t3_pixel", 32'(pix_a), 32'h1234);
        en_a = 1'b0;
        step();

        // Enable dropped after byte 0: pixel still completes, then idle
        en_a = 1'b1;
        step();
        step();
        step();
        en_a = 1'b0;
        #2;
        check("t4_read1_no_enable", 32'(rd_a), 32'd1);
        step();
        step();
        check("t4_valid", 32'(valid_a), 32'd1);
        check("t4_pixel", 32'(pix_a), 32'hABCD);
        n = 0;
        for (int k = 0; k < 5; k++) begin
            step();
            n += int'(rd_a) + int'(valid_a);
        end
        check("t4_idle_quiet", 32'(n), 32'd0);

        // Reset during WAIT of byte 1 drops the partial pixel and the in-flight byte
        en_a = 1'b1;
        for (int k = 1; k <= 4; k++) step();
        rst = 1'b1;
        #1;
        check("t5_rst_read", 32'(rd_a), 32'd0);
        check("t5_rst_valid", 32'(valid_a), 32'd0);
        check("t5_rst_pixel", 32'(pix_a), 32'd0);
`ifdef PIXEL_STREAMER_UNDERRUN_COUNT_EN
        check("t5_rst_ucnt", 32'(ucnt_a), 32'd0);
`endif
        step();
        rst = 1'b0;
        for (int k = 1; k <= 5; k++) step();
        check("t5_valid", 32'(valid_a), 32'd1);
        check("t5_pixel", 32'(pix_a), 32'h3322);
        en_a = 1'b0;
        step();

        // 3 bytes per pixel, latency 2: one read every 3 cycles
        en_b = 1'b1;
        n    = 0;
        for (int k = 1; k <= 10; k++) begin
            step();
            if (rd_b != (k == 1 || k == 4 || k == 7)) n++;
            if (valid_b != (k == 10)) n++;
        end
        check("t6_timing", 32'(n), 32'd0);
        check("t6_pixel", 32'(pix_b), 32'hCCBBAA);
        en_b = 1'b0;
        step();
        check("t6_valid_drop", 32'(valid_b), 32'd0);
        check("t6_underrun_b", 32'(underrun_b), 32'd0);

        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
